data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate L1 data cache between the pipeline MEM stage and data_memory.
- Read hits return in the same cycle.
- Read misses stall the pipeline and fetch a 4-word (128-bit) line from data_memory using its READY handshake.
- Writes go straight through to data_memory and also update the cached copy on a hit.

---
 rtl/data_cache_pkg.sv | 19 +
 rtl/cache_line_array.sv | 57 +++++
 rtl/data_cache.sv | 144 ++++++++++++++
 tb/tb_data_cache.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared constants, FSM encoding and word-select helper for the L1 data cache.
package data_cache_pkg;

    localparam int LINE_W     = 128;
    localparam int WORD_W     = 32;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0] off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/line storage: combinational read, synchronous line fill and word write.
module cache_line_array
    import data_cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3,
    parameter int TAG_W    = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [1:0]        wr_off,
    input  logic [WORD_W-1:0] wr_data
);

    logic [NUM_SETS-1:0] valid_r;
    logic [TAG_W-1:0]    tags_r  [NUM_SETS];
    logic [LINE_W-1:0]   lines_r [NUM_SETS];
    logic                wr_ok_s;

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tags_r[rd_idx];
    assign rd_line  = lines_r[rd_idx];

    // A fill to the same set wins over a word write.
    assign wr_ok_s = wr_en && !(fill_en && (fill_idx == wr_idx));

    // Valid bits: cleared asynchronously, set by a line fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[fill_idx] <= 1'b1;
        end
    end

    // Tag and line data: no reset needed since valid gates every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags_r[fill_idx]  <= fill_tag;
            lines_r[fill_idx] <= fill_line;
        end
        if (wr_ok_s) begin
            lines_r[wr_idx][{wr_off, 5'd0} +: WORD_W] <= wr_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with line-fill FSM
// and saturating hit/miss statistics.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic              Stall,
    output logic              mem_WE,
    output logic [31:0]       mem_A,
    output logic [31:0]       mem_WD,
    input  logic              mem_READY,
    input  logic [LINE_W-1:0] mem_RD,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int TAG_LSB = INDEX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    state_t             state_r;
    logic [31:0]        miss_addr_r;
    logic [1:0]         offset_s;
    logic [IDX_W-1:0]   index_s;
    logic [TAG_W-1:0]   tag_s;
    logic               rd_valid_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [LINE_W-1:0]  rd_line_s;
    logic               hit_s;
    logic               fill_en_s;
    logic               wr_en_s;
    logic               unused_bits;

    assign offset_s    = A[INDEX_LSB-1:OFFSET_LSB];
    assign index_s     = A[TAG_LSB-1:INDEX_LSB];
    assign tag_s       = A[31:TAG_LSB];
    assign hit_s       = rd_valid_s && (rd_tag_s == tag_s);
    assign unused_bits = &{1'b0, A[OFFSET_LSB-1:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    cache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (index_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_line   (rd_line_s),
        .fill_en   (fill_en_s),
        .fill_idx  (miss_addr_r[TAG_LSB-1:INDEX_LSB]),
        .fill_tag  (miss_addr_r[31:TAG_LSB]),
        .fill_line (mem_RD),
        .wr_en     (wr_en_s),
        .wr_idx    (index_s),
        .wr_off    (offset_s),
        .wr_data   (WD)
    );

    // CPU-facing and memory-facing outputs; forced quiet while reset is asserted.
    always_comb begin
        RD        = 32'h0;
        Stall     = 1'b0;
        mem_WE    = 1'b0;
        mem_A     = 32'h0;
        mem_WD    = 32'h0;
        fill_en_s = 1'b0;
        wr_en_s   = 1'b0;
        if (!rst) begin
            Stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (MemWrite) begin
                        mem_WE  = 1'b1;
                        mem_A   = A;
                        mem_WD  = WD;
                        wr_en_s = hit_s;
                    end else if (MemRead) begin
                        Stall = !hit_s;
                        RD    = hit_s ? line_word(rd_line_s, offset_s) : 32'h0;
                    end else begin
                        mem_A = 32'h0;
                    end
                end
                FETCH: begin
                    Stall     = 1'b1;
                    mem_A     = miss_addr_r;
                    fill_en_s = mem_READY;
                end
                default: begin
                    Stall = 1'b0;
                end
            endcase
        end
    end

    // FSM, miss-address latch and saturating statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            miss_addr_r <= 32'h0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (MemRead && !MemWrite) begin
                        if (hit_s) begin
                            hit_count <= sat_inc(hit_count);
                        end else begin
                            miss_addr_r <= {A[31:INDEX_LSB], 4'b0000};
                            miss_count  <= sat_inc(miss_count);
                            state_r     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (mem_READY) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a behavioural data_memory (2-cycle line-read latency).
module tb_data_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  A;
    logic [31:0]  WD;
    logic [31:0]  RD;
    logic         Stall;
    logic         mem_WE;
    logic [31:0]  mem_A;
    logic [31:0]  mem_WD;
    logic         mem_READY;
    logic [127:0] mem_RD;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    logic [31:0]  mem [0:255] = '{default: 32'h0};
    int           wait_cnt = 0;
    logic         ready_force = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    data_cache #(.NUM_SETS(8), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .A          (A),
        .WD         (WD),
        .RD         (RD),
        .Stall      (Stall),
        .mem_WE     (mem_WE),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_READY  (mem_READY),
        .mem_RD     (mem_RD),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    assign mem_RD    = {mem[{mem_A[9:4], 2'd3}], mem[{mem_A[9:4], 2'd2}],
                        mem[{mem_A[9:4], 2'd1}], mem[{mem_A[9:4], 2'd0}]};
    assign mem_READY = ready_force || (wait_cnt == 2);

    always @(posedge clk) begin
        if (mem_WE) mem[mem_A[9:2]] <= mem_WD;
        wait_cnt <= (Stall && !mem_WE) ? wait_cnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; A = a; WD = d;
        #1;
        chk("st_we", {31'h0, mem_WE}, 32'h1);
        chk("st_addr", mem_A, a);
        chk("st_wd", mem_WD, d);
        chk("st_stall", {31'h0, Stall}, 32'h0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input bit miss);
        int stalls;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; A = a; WD = 32'h0;
        #1;
        stalls = 0;
        if (miss) begin
            chk("miss_stall", {31'h0, Stall}, 32'h1);
            chk("miss_rd0", RD, 32'h0);
        end
        while (Stall && stalls < 20) begin
            @(negedge clk);
            #1;
            stalls++;
            if (stalls == 1) begin
                chk("fetch_addr", mem_A, {a[31:4], 4'h0});
                chk("fetch_we", {31'h0, mem_WE}, 32'h0);
            end
        end
        chk("stall_cycles", stalls, miss ? 32'd3 : 32'd0);
        chk("load_rd", RD, exp);
    endtask

    task automatic idle_chk(input logic [31:0] exp_hit, input logic [31:0] exp_miss);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; A = 32'h0; WD = 32'h0;
        #1;
        chk("idle_stall", {31'h0, Stall}, 32'h0);
        chk("idle_mem_a", mem_A, 32'h0);
        chk("idle_rd", RD, 32'h0);
        chk("hit_count", hit_count, exp_hit);
        chk("miss_count", miss_count, exp_miss);
    endtask

    initial begin
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; A = 32'h0; WD = 32'h0;
        #3;
        chk("rst_stall", {31'h0, Stall}, 32'h0);
        chk("rst_we", {31'h0, mem_WE}, 32'h0);
        chk("rst_mem_a", mem_A, 32'h0);
        chk("rst_mem_wd", mem_WD, 32'h0);
        chk("rst_rd", RD, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_misses", miss_count, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        do_store(32'h0, 32'hAAAAAAAA);
        do_store(32'h4, 32'hBBBBBBBB);
        do_store(32'h8, 32'hCCCCCCCC);
        do_store(32'hC, 32'hDDDDDDDD);
        idle_chk(32'd0, 32'd0);

        do_load(32'h4, 32'hBBBBBBBB, 1'b1);
        idle_chk(32'd1, 32'd1);

        do_load(32'h0, 32'hAAAAAAAA, 1'b0);
        do_load(32'h8, 32'hCCCCCCCC, 1'b0);
        do_load(32'hC, 32'hDDDDDDDD, 1'b0);
        idle_chk(32'd4, 32'd1);

        do_store(32'h8, 32'h12345678);
        do_load(32'h8, 32'h12345678, 1'b0);
        idle_chk(32'd5, 32'd1);
        do_load(32'h80, 32'h0, 1'b1);
        idle_chk(32'd6, 32'd2);
        do_load(32'h8, 32'h12345678, 1'b1);
        idle_chk(32'd7, 32'd3);

        // Write miss must not allocate.
        do_store(32'h40, 32'h0BADF00D);
        do_load(32'h40, 32'h0BADF00D, 1'b1);
        idle_chk(32'd8, 32'd4);

        // Stray READY while idle is ignored.
        @(negedge clk);
        ready_force = 1'b1;
        #1;
        chk("ready_idle_stall", {31'h0, Stall}, 32'h0);
        chk("ready_idle_mem_a", mem_A, 32'h0);
        @(negedge clk);
        ready_force = 1'b0;
        do_load(32'h4, 32'hBBBBBBBB, 1'b0);
        idle_chk(32'd9, 32'd4);

        // Reset in the middle of a fetch.
        @(negedge clk);
        MemRead = 1'b1; A = 32'h84;
        #1;
        chk("miss84_stall", {31'h0, Stall}, 32'h1);
        @(negedge clk);
        #1;
        chk("fetch84_addr", mem_A, 32'h80);
        rst = 1'b0;
        #1;
        chk("midrst_stall", {31'h0, Stall}, 32'h0);
        chk("midrst_we", {31'h0, mem_WE}, 32'h0);
        chk("midrst_rd", RD, 32'h0);
        chk("midrst_hits", hit_count, 32'h0);
        chk("midrst_misses", miss_count, 32'h0);
        @(negedge clk);
        MemRead = 1'b0; A = 32'h0;
        rst = 1'b1;
        do_load(32'h4, 32'hBBBBBBBB, 1'b1);
        idle_chk(32'd1, 32'd1);

        // Simultaneous read and write behaves as a write.
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b1; A = 32'hC; WD = 32'hEEEEEEEE;
        #1;
        chk("rw_we", {31'h0, mem_WE}, 32'h1);
        chk("rw_stall", {31'h0, Stall}, 32'h0);
        chk("rw_mem_a", mem_A, 32'hC);
        chk("rw_mem_wd", mem_WD, 32'hEEEEEEEE);
        idle_chk(32'd1, 32'd1);
        do_load(32'hC, 32'hEEEEEEEE, 1'b0);
        idle_chk(32'd2, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
